mfp_uart_transmitter: RTL and testbench

- Serial 8N1 UART transmitter: the transmit-side counterpart of mfp_uart_receiver, providing a TX path so the board can echo loader status or software output to the host.
- Accepts bytes over a valid/ready handshake into a small byte FIFO and serialises them on a single TX line at a fixed baud rate.
- Sits beside mfp_uart_receiver under the loader/AHB top level; a memory-mapped AHB register feeds byte_data/byte_valid.

---
 rtl/mfp_uart_transmitter.sv | 224 ++++++++++++++++++++++
 tb/tb_mfp_uart_transmitter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mfp_uart_transmitter.sv
// 8N1 UART transmitter: byte FIFO feeding a registered serial TX line, LSB first.
// Latency: byte into empty FIFO while idle starts its frame one edge later; backpressure: byte_ready low only when FIFO full.

module mfp_uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push_vld,
    input  logic [7:0]            push_dat,
    output logic                  push_rdy,
    input  logic                  pop,
    output logic [7:0]            head_dat,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  do_push;
    logic                  do_pop;

    // Ready comes from the registered count only, so a same-cycle pop never opens a full FIFO.
    assign push_rdy = (count_q != FULL_COUNT);
    assign do_push  = push_vld & push_rdy;
    assign do_pop   = pop & (count_q != '0);
    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end
endmodule

module mfp_uart_transmitter #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int BAUD_RATE       = 115200,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [7:0]                 byte_data,
    input  logic                       byte_valid,
    output logic                       byte_ready,
    output logic                       tx,
    output logic                       busy,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_count
);
    localparam int DIVIDER = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int DIV_W   = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVIDER - 1);

    generate
        if (DIVIDER < 2) begin : g_bad_divider
            $error("mfp_uart_transmitter: CLOCK_FREQUENCY / BAUD_RATE must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             tx_q, tx_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             pop;
    logic [7:0]       head_dat;
    logic             fifo_empty;
    logic             bit_end;

    mfp_uart_tx_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push_vld (byte_valid),
        .push_dat (byte_data),
        .push_rdy (byte_ready),
        .pop      (pop),
        .head_dat (head_dat),
        .count    (fifo_count)
    );

    assign fifo_empty = (fifo_count == '0);
    assign bit_end    = (div_cnt_q == DIV_LAST);
    assign tx         = tx_q;
    assign busy       = (state_q != ST_IDLE) | ~fifo_empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            tx_q      <= 1'b1;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end && (bit_cnt_q == 3'd7)) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    state_d = fifo_empty ? ST_IDLE : ST_START;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_d      = tx_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q + 1'b1;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                div_cnt_d = '0;
                tx_d      = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = head_dat;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    div_cnt_d = '0;
                    if (bit_cnt_q == 3'd7) begin
                        tx_d = 1'b1;
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    div_cnt_d = '0;
                    // Chain straight into the next start bit so back-to-back frames have no idle gap.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = head_dat;
                        tx_d    = 1'b0;
                    end
                end
            end
            default: begin
                div_cnt_d = '0;
                tx_d      = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_mfp_uart_transmitter.sv
// Directed bench for mfp_uart_transmitter with a serial-line decoder and byte scoreboard.
module tb_mfp_uart_transmitter;
    localparam int CF  = 1000000;
    localparam int BR  = 100000;
    localparam int FDL = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [7:0]     byte_data = 8'h00;
    logic           byte_valid = 1'b0;
    logic           byte_ready;
    logic           tx;
    logic           busy;
    logic [FDL:0]   fifo_count;

    int             cyc = 0;
    int             n_assert = 0;
    int             n_fail = 0;
    int             frames = 0;
    bit             abort_frame = 1'b0;
    bit             saw_full = 1'b0;
    logic [7:0]     sbq[$];
    int             start_q[$];

    mfp_uart_transmitter #(
        .CLOCK_FREQUENCY (CF),
        .BAUD_RATE       (BR),
        .FIFO_DEPTH_LOG2 (FDL)
    ) dut (
        .clock      (clk),
        .reset      (rst),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one byte and hold it until accepted; called at a negedge, returns at a negedge.
    task automatic push_hold(input logic [7:0] b, output int acc_cyc);
        int guard;
        guard      = 0;
        acc_cyc    = -1;
        byte_valid = 1'b1;
        byte_data  = b;
        forever begin
            check("ready_vs_count", byte_ready, (fifo_count != 5'd16));
            if (fifo_count == 5'd16) saw_full = 1'b1;
            if (byte_ready) begin
                sbq.push_back(b);
                acc_cyc = cyc;
                @(negedge clk);
                break;
            end
            guard++;
            if (guard > 300) begin
                check("push_accepted", byte_ready, 1);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("drain_busy", busy, 0);
        repeat (2) @(negedge clk);
        check("sb_empty", sbq.size(), 0);
    endtask

    // Line decoder: sample each bit mid-period and compare the byte against the scoreboard.
    initial begin
        logic [7:0] rx;
        int         sc;
        bit         ab;
        logic       st;
        logic       sp;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                sc = cyc;
                ab = abort_frame;
                repeat (4) @(negedge clk);
                st = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (10) @(negedge clk);
                    rx[i] = tx;
                end
                repeat (10) @(negedge clk);
                sp = tx;
                ab = ab | abort_frame;
                if (!ab) begin
                    start_q.push_back(sc);
                    frames++;
                    check("start_bit", st, 0);
                    check("stop_bit", sp, 1);
                    check("frame_expected", (sbq.size() != 0), 1);
                    if (sbq.size() != 0) check("rx_byte", rx, sbq.pop_front());
                end
            end
        end
    end

    initial begin
        int acc;
        int k_cyc;
        int acc17;
        int fr0;
        bit low_seen;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_ready", byte_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_count", fifo_count, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single byte 0x55: latency and frame length
        start_q.delete();
        push_hold(8'h55, acc);
        byte_valid = 1'b0;
        k_cyc = cyc;
        check("single_count_after_push", fifo_count, 1);
        check("single_tx_idle_at_k", tx, 1);
        check("single_busy_at_k", busy, 1);
        @(negedge clk);
        check("single_tx_low_k1", tx, 0);
        check("single_count_k1", fifo_count, 0);
        repeat (99) @(negedge clk);
        check("single_busy_k100", busy, 1);
        @(negedge clk);
        check("single_busy_k101", busy, 0);
        check("single_tx_k101", tx, 1);
        check("single_frames", start_q.size(), 1);
        if (start_q.size() == 1) check("single_latency", start_q[0], k_cyc + 1);
        wait_idle(50);

        // Back-to-back frames
        start_q.delete();
        push_hold(8'h00, acc);
        push_hold(8'hFF, acc);
        push_hold(8'hA3, acc);
        byte_valid = 1'b0;
        wait_idle(400);
        check("b2b_frames", start_q.size(), 3);
        if (start_q.size() == 3) begin
            check("b2b_gap01", start_q[1] - start_q[0], 100);
            check("b2b_gap12", start_q[2] - start_q[1], 100);
        end

        // FIFO full: 18 bytes offered back to back, 17 accepted before the second frame
        start_q.delete();
        saw_full = 1'b0;
        acc17 = -1;
        for (int b = 0; b < 18; b++) begin
            push_hold(8'h30 + 8'(b), acc);
            if (b == 17) acc17 = acc;
        end
        byte_valid = 1'b0;
        check("full_reached", saw_full, 1);
        wait_idle(2500);
        check("full_frames", start_q.size(), 18);
        if (start_q.size() >= 2) check("full_ready_after_pop", acc17, start_q[1]);

        // Reset mid-frame with four bytes queued
        start_q.delete();
        for (int b = 0; b < 5; b++) push_hold(8'hC0 + 8'(b), acc);
        byte_valid = 1'b0;
        repeat (40) @(negedge clk);
        check("rstmid_count_before", fifo_count, 4);
        abort_frame = 1'b1;
        rst = 1'b1;
        byte_valid = 1'b1;
        byte_data = 8'hEE;
        @(negedge clk);
        rst = 1'b0;
        byte_valid = 1'b0;
        check("rstmid_tx", tx, 1);
        check("rstmid_count", fifo_count, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_ready", byte_ready, 1);
        sbq.delete();
        low_seen = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1) low_seen = 1'b1;
        end
        check("rstmid_no_frames", low_seen, 0);
        abort_frame = 1'b0;

        // Pointer wrap-around: 40 incrementing bytes
        fr0 = frames;
        for (int b = 0; b < 40; b++) push_hold(8'(b), acc);
        byte_valid = 1'b0;
        wait_idle(5000);
        check("wrap_frames", frames - fr0, 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
